// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one outstanding AXI-lite read at a time, with redirect/kill handling.
// Optional build macro IFU_ACCESS_FAULT_EN turns error responses into a faulting NOP and stops fetch until a redirect.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_inst,
    output logic        out_fault
);

    // state  | meaning
    // ADDR   | AR channel owned; arvalid low only right after reset or while halted on a fault
    // WAIT_R | AR accepted, waiting for the read response
    // HOLD   | instruction presented to decode
    typedef enum logic [1:0] {
        ADDR   = 2'd0,
        WAIT_R = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_pend_pc;
    logic        r_kill;
    logic        r_halt;
    logic        r_arvalid;
    logic        r_rready;
    logic        r_out_valid;
    logic [31:0] r_out_pc;
    logic [31:0] r_out_inst;
    logic        r_out_fault;

    logic [31:0] w_redirect_pc;
    logic        w_resp_err;
    logic        w_unused;

    assign w_redirect_pc = {redirect_pc[31:2], 2'b00};

`ifdef IFU_ACCESS_FAULT_EN
    assign w_resp_err = (rresp != 2'b00);
    assign w_unused   = ^redirect_pc[1:0];
`else
    assign w_resp_err = 1'b0;
    assign w_unused   = ^{redirect_pc[1:0], rresp};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ADDR;
            r_pc        <= RESET_PC;
            r_pend_pc   <= RESET_PC;
            r_kill      <= 1'b0;
            r_halt      <= 1'b0;
            r_arvalid   <= 1'b0;
            r_rready    <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_pc    <= 32'h0;
            r_out_inst  <= 32'h0;
            r_out_fault <= 1'b0;
        end else begin
            case (r_state)
                ADDR: begin
                    if (!r_arvalid) begin
                        // Idle: first cycle out of reset, or parked after a fault
                        if (redirect_valid) begin
                            r_pc      <= w_redirect_pc;
                            r_arvalid <= 1'b1;
                            r_halt    <= 1'b0;
                        end else if (!r_halt) begin
                            r_arvalid <= 1'b1;
                        end
                    end else begin
                        if (redirect_valid) begin
                            r_pend_pc <= w_redirect_pc;
                            r_kill    <= 1'b1;
                        end
                        if (arready) begin
                            r_arvalid <= 1'b0;
                            r_rready  <= 1'b1;
                            r_state   <= WAIT_R;
                        end
                    end
                end
                WAIT_R: begin
                    if (rvalid) begin
                        r_rready <= 1'b0;
                        if (r_kill || redirect_valid) begin
                            // A redirect landing on the handshake itself beats the pending target
                            r_pc      <= redirect_valid ? w_redirect_pc : r_pend_pc;
                            r_kill    <= 1'b0;
                            r_arvalid <= 1'b1;
                            r_state   <= ADDR;
                        end else begin
                            r_out_valid <= 1'b1;
                            r_out_pc    <= r_pc;
                            r_out_inst  <= w_resp_err ? NOP_INST : rdata;
                            r_out_fault <= w_resp_err;
                            r_state     <= HOLD;
                        end
                    end else if (redirect_valid) begin
                        r_pend_pc <= w_redirect_pc;
                        r_kill    <= 1'b1;
                    end
                end
                HOLD: begin
                    if (redirect_valid) begin
                        r_out_valid <= 1'b0;
                        r_out_fault <= 1'b0;
                        r_pc        <= w_redirect_pc;
                        r_arvalid   <= 1'b1;
                        r_halt      <= 1'b0;
                        r_state     <= ADDR;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_out_fault <= 1'b0;
                        r_state     <= ADDR;
                        if (r_out_fault) begin
                            r_halt <= 1'b1;
                        end else begin
                            r_pc      <= r_pc + 32'd4;
                            r_arvalid <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ADDR;
                end
            endcase
        end
    end

    assign araddr    = r_pc;
    assign arvalid   = r_arvalid;
    assign rready    = r_rready;
    assign out_valid = r_out_valid;
    assign out_pc    = r_out_pc;
    assign out_inst  = r_out_inst;
    assign out_fault = r_out_fault;

endmodule
